// File: rtl/dma_axi_w.sv
// dma_axi_w: single-burst AXI write master.
// Takes a burst request (addr + dma_len) from the databus side, issues one AW
// transaction, streams the beats straight through to the W channel and then
// waits for the B response, recording whether it reported an error.

`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif
`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif
`ifndef AXI_SIZE_W
`define AXI_SIZE_W 3
`endif
`ifndef AXI_BURST_W
`define AXI_BURST_W 2
`endif
`ifndef AXI_LOCK_W
`define AXI_LOCK_W 1
`endif
`ifndef AXI_CACHE_W
`define AXI_CACHE_W 4
`endif
`ifndef AXI_PROT_W
`define AXI_PROT_W 3
`endif
`ifndef AXI_QOS_W
`define AXI_QOS_W 4
`endif
`ifndef AXI_RESP_W
`define AXI_RESP_W 2
`endif

module dma_axi_w #(
  parameter int ADDR_W     = `AXI_ADDR_W,
  parameter int DMA_DATA_W = 32
) (
  input  logic                      clk,
  input  logic                      rst,

  // databus side
  input  logic                      valid,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [DMA_DATA_W-1:0]     wdata,
  input  logic [DMA_DATA_W/8-1:0]   wstrb,
  output logic                      ready,

  // burst control
  input  logic [`AXI_LEN_W-1:0]     dma_len,
  output logic                      dma_ready,
  output logic                      error,

  // AW channel
  output logic [`AXI_ID_W-1:0]      m_axi_awid,
  output logic [ADDR_W-1:0]         m_axi_awaddr,
  output logic [`AXI_LEN_W-1:0]     m_axi_awlen,
  output logic [`AXI_SIZE_W-1:0]    m_axi_awsize,
  output logic [`AXI_BURST_W-1:0]   m_axi_awburst,
  output logic [`AXI_LOCK_W-1:0]    m_axi_awlock,
  output logic [`AXI_CACHE_W-1:0]   m_axi_awcache,
  output logic [`AXI_PROT_W-1:0]    m_axi_awprot,
  output logic [`AXI_QOS_W-1:0]     m_axi_awqos,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,

  // W channel
  output logic [DMA_DATA_W-1:0]     m_axi_wdata,
  output logic [DMA_DATA_W/8-1:0]   m_axi_wstrb,
  output logic                      m_axi_wlast,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,

  // B channel
  input  logic [`AXI_RESP_W-1:0]    m_axi_bresp,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready
);

  typedef logic [`AXI_SIZE_W-1:0] size_t;
  typedef logic [`AXI_LEN_W-1:0]  len_t;

  typedef enum logic [1:0] {
    W_ADDR_HS,
    W_DATA,
    W_RESP
  } state_t;

  state_t state_q, state_d;
  len_t   counter_q, counter_d;
  len_t   len_q, len_d;
  logic   awvalid_q, awvalid_d;
  logic   error_q, error_d;
  logic   dma_ready_q, dma_ready_d;

  logic   beat;

  // Fixed AW attributes: INCR bursts of full-width beats
  assign m_axi_awid    = '0;
  assign m_axi_awaddr  = addr;
  assign m_axi_awlen   = len_q;
  assign m_axi_awsize  = size_t'($clog2(DMA_DATA_W / 8));
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = '0;
  assign m_axi_awcache = 4'h2;
  assign m_axi_awprot  = 3'b010;
  assign m_axi_awqos   = '0;
  assign m_axi_awvalid = awvalid_q;

  // Beat data goes straight through; handshake is qualified by state
  assign m_axi_wdata  = wdata;
  assign m_axi_wstrb  = wstrb;
  assign m_axi_wvalid = (state_q == W_DATA) && valid;
  assign ready        = (state_q == W_DATA) && valid && m_axi_wready;
  assign m_axi_wlast  = (state_q == W_DATA) && (counter_q == len_q);
  assign m_axi_bready = (state_q == W_RESP);

  assign beat      = ready;
  assign dma_ready = dma_ready_q;
  assign error     = error_q;

  // Next-state logic for the AW -> W -> B sequence
  always_comb begin
    state_d     = state_q;
    counter_d   = counter_q;
    len_d       = len_q;
    awvalid_d   = awvalid_q;
    error_d     = error_q;
    dma_ready_d = dma_ready_q;

    case (state_q)
      W_ADDR_HS: begin
        if (!awvalid_q) begin
          counter_d   = '0;
          dma_ready_d = 1'b1;
          if (valid) begin
            awvalid_d   = 1'b1;
            len_d       = dma_len;
            dma_ready_d = 1'b0;
          end
        end else if (m_axi_awready) begin
          awvalid_d = 1'b0;
          state_d   = W_DATA;
        end
      end

      W_DATA: begin
        if (beat) begin
          counter_d = counter_q + len_t'(1);
          if (m_axi_wlast) state_d = W_RESP;
        end
      end

      W_RESP: begin
        if (m_axi_bvalid) begin
          error_d = (m_axi_bresp != 2'b00);
          state_d = W_ADDR_HS;
        end
      end

      default: state_d = W_ADDR_HS;
    endcase
  end

  // State registers; reset aborts any burst in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= W_ADDR_HS;
      counter_q   <= '0;
      len_q       <= '0;
      awvalid_q   <= 1'b0;
      error_q     <= 1'b0;
      dma_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      counter_q   <= counter_d;
      len_q       <= len_d;
      awvalid_q   <= awvalid_d;
      error_q     <= error_d;
      dma_ready_q <= dma_ready_d;
    end
  end

endmodule

// File: tb/tb_dma_axi_w.sv
// Directed bench for dma_axi_w: normal bursts, AW back-pressure, single-beat
// bursts, W back-pressure, error responses and reset in the middle of a burst.

`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif
`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif
`ifndef AXI_SIZE_W
`define AXI_SIZE_W 3
`endif
`ifndef AXI_BURST_W
`define AXI_BURST_W 2
`endif
`ifndef AXI_LOCK_W
`define AXI_LOCK_W 1
`endif
`ifndef AXI_CACHE_W
`define AXI_CACHE_W 4
`endif
`ifndef AXI_PROT_W
`define AXI_PROT_W 3
`endif
`ifndef AXI_QOS_W
`define AXI_QOS_W 4
`endif
`ifndef AXI_RESP_W
`define AXI_RESP_W 2
`endif

module tb_dma_axi_w;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    valid;
  logic [31:0]             addr;
  logic [31:0]             wdata;
  logic [3:0]              wstrb;
  logic                    ready;
  logic [`AXI_LEN_W-1:0]   dma_len;
  logic                    dma_ready;
  logic                    error;
  logic [`AXI_ID_W-1:0]    m_axi_awid;
  logic [31:0]             m_axi_awaddr;
  logic [`AXI_LEN_W-1:0]   m_axi_awlen;
  logic [`AXI_SIZE_W-1:0]  m_axi_awsize;
  logic [`AXI_BURST_W-1:0] m_axi_awburst;
  logic [`AXI_LOCK_W-1:0]  m_axi_awlock;
  logic [`AXI_CACHE_W-1:0] m_axi_awcache;
  logic [`AXI_PROT_W-1:0]  m_axi_awprot;
  logic [`AXI_QOS_W-1:0]   m_axi_awqos;
  logic                    m_axi_awvalid;
  logic                    m_axi_awready;
  logic [31:0]             m_axi_wdata;
  logic [3:0]              m_axi_wstrb;
  logic                    m_axi_wlast;
  logic                    m_axi_wvalid;
  logic                    m_axi_wready;
  logic [`AXI_RESP_W-1:0]  m_axi_bresp;
  logic                    m_axi_bvalid;
  logic                    m_axi_bready;

  int  total = 0;
  int  bad   = 0;
  logic exp_err = 1'b0;

  always #5 clk = ~clk;

  dma_axi_w #(.ADDR_W(32), .DMA_DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .valid(valid), .addr(addr), .wdata(wdata), .wstrb(wstrb), .ready(ready),
    .dma_len(dma_len), .dma_ready(dma_ready), .error(error),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete burst. stall = cycles awready stays low with awvalid up,
  // tog = wready alternates 1/0 during the data phase, br = B response.
  task automatic run_burst(input logic [31:0] a, input logic [7:0] len,
                           input int stall, input bit tog, input logic [1:0] br);
    int beats = 0;
    int cyc = 0;
    bit done;
    check("idle_dma_ready", dma_ready, 1);
    check("idle_awvalid", m_axi_awvalid, 0);
    addr = a; dma_len = len; valid = 1'b1;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0;
    step();
    dma_len = 8'hEE;  // only the value at request time may matter
    check("aw_valid", m_axi_awvalid, 1);
    check("aw_addr", m_axi_awaddr, a);
    check("aw_len", m_axi_awlen, len);
    check("req_dma_ready", dma_ready, 0);
    check("req_ready", ready, 0);
    check("req_wvalid", m_axi_wvalid, 0);
    for (int i = 0; i < stall; i++) begin
      step();
      check("stall_awvalid", m_axi_awvalid, 1);
      check("stall_awaddr", m_axi_awaddr, a);
      check("stall_awlen", m_axi_awlen, len);
      check("stall_wvalid", m_axi_wvalid, 0);
    end
    m_axi_awready = 1'b1;
    step();
    m_axi_awready = 1'b0;
    check("aw_done", m_axi_awvalid, 0);
    done = 1'b0;
    while (!done && cyc < 64) begin
      m_axi_wready = tog ? (cyc % 2 == 0) : 1'b1;
      wdata = {a[15:0], 16'(beats) ^ 16'h5A5A};
      wstrb = 4'(beats + 1);
      #1;
      check("w_valid", m_axi_wvalid, 1);
      check("w_ready_mirror", ready, m_axi_wready);
      check("w_last", m_axi_wlast, (beats == int'(len)));
      check("w_data", m_axi_wdata, wdata);
      check("w_strb", m_axi_wstrb, wstrb);
      check("w_bready", m_axi_bready, 0);
      check("w_error_hold", error, exp_err);
      done = m_axi_wready && (beats == int'(len));
      if (m_axi_wready) beats++;
      @(posedge clk); #1;
      cyc++;
    end
    check("beat_count", beats, int'(len) + 1);
    valid = 1'b0; m_axi_wready = 1'b0;
    #1;
    check("resp_bready", m_axi_bready, 1);
    check("resp_ready", ready, 0);
    check("resp_wvalid", m_axi_wvalid, 0);
    check("resp_awvalid", m_axi_awvalid, 0);
    step();
    check("resp_wait_bready", m_axi_bready, 1);
    check("resp_wait_error", error, exp_err);
    m_axi_bvalid = 1'b1; m_axi_bresp = br;
    step();
    m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    exp_err = (br != 2'b00);
    check("b_done_dma_ready", dma_ready, 0);
    check("b_done_bready", m_axi_bready, 0);
    check("b_error", error, exp_err);
    step();
    check("back_dma_ready", dma_ready, 1);
    check("back_error", error, exp_err);
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; addr = '0; wdata = '0; wstrb = '0; dma_len = '0;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bresp = '0; m_axi_bvalid = 1'b0;
    #1;
    check("rst_dma_ready", dma_ready, 1);
    check("rst_awvalid", m_axi_awvalid, 0);
    check("rst_error", error, 0);
    check("rst_ready", ready, 0);
    check("rst_wvalid", m_axi_wvalid, 0);
    check("rst_bready", m_axi_bready, 0);
    check("rst_awlen", m_axi_awlen, 0);
    check("awsize", m_axi_awsize, 2);
    check("awburst", m_axi_awburst, 1);
    check("awcache", m_axi_awcache, 4'h2);
    check("awprot", m_axi_awprot, 3'b010);
    check("awid_qos_lock", {m_axi_awid, m_axi_awqos, m_axi_awlock}, 0);
    step(); step();
    rst = 1'b0;
    step();

    run_burst(32'h0000_1000, 8'd3, 0, 1'b0, 2'b00);  // basic 4-beat burst
    run_burst(32'h0000_2040, 8'd2, 5, 1'b0, 2'b00);  // AW held off 5 cycles
    run_burst(32'h0000_3000, 8'd0, 0, 1'b0, 2'b00);  // single beat
    run_burst(32'h0000_4000, 8'd7, 0, 1'b1, 2'b00);  // wready toggling
    run_burst(32'h0000_5000, 8'd1, 1, 1'b0, 2'b10);  // SLVERR -> error
    run_burst(32'h0000_6000, 8'd1, 0, 1'b0, 2'b00);  // OKAY clears error
    run_burst(32'h0000_7000, 8'd0, 0, 1'b0, 2'b11);  // DECERR -> error

    // reset while beat 2 of 4 is on the bus
    addr = 32'h0000_8000; dma_len = 8'd3; valid = 1'b1; m_axi_awready = 1'b1;
    step();
    step();
    m_axi_awready = 1'b0; m_axi_wready = 1'b1;
    step(); step();
    check("pre_rst_ready", ready, 1);
    check("pre_rst_wlast", m_axi_wlast, 0);
    check("pre_rst_error", error, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_ready", ready, 0);
    check("mid_rst_wvalid", m_axi_wvalid, 0);
    check("mid_rst_wlast", m_axi_wlast, 0);
    check("mid_rst_awvalid", m_axi_awvalid, 0);
    check("mid_rst_dma_ready", dma_ready, 1);
    check("mid_rst_error", error, 0);
    check("mid_rst_bready", m_axi_bready, 0);
    check("mid_rst_awlen", m_axi_awlen, 0);
    exp_err = 1'b0;
    valid = 1'b0; m_axi_wready = 1'b0;
    step();
    rst = 1'b0;
    step();
    run_burst(32'h0000_9000, 8'd3, 0, 1'b0, 2'b00);  // clean burst after abort

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // hard stop in case the stimulus ever stalls
  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
